md_seq_controller: RTL and testbench
====================================

Name: md_seq_controller

Overview:
- Next-generation ID-stage controller: full RV32I decode plus RV32M, with deterministic (non-x) outputs and an illegal-instruction flag.
- Adds a multi-cycle sequencer that starts the external mul/div unit, stalls IF/ID for a parametrised latency, and handles flush and hazard-stall interaction.
- Sits in ID, alongside the hazard unit. Outputs feed the ID/EX pipeline register.

Parameters:
- MUL_LATENCY, 3, EX cycles for MUL/MULH/MULHSU/MULHU; must be >= 1.
- DIV_LATENCY, 33, EX cycles for DIV/DIVU/REM/REMU; must be >= 1.
- CNT_W, 6, down-counter width; must hold max(MUL_LATENCY, DIV_LATENCY) - 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  ID holds a valid instruction
- opcode  in  5  instruction[6:2]
- fun3  in  3  instruction[14:12]
- fun7  in  7  instruction[31:25]
- stall_in  in  1  hazard-unit stall (load-use)
- flush  in  1  kill the ID instruction (branch/jump taken)
- imm_sel  out  3  immgen_t
- alu_src_b  out  1  0 = rs2, 1 = imm
- mem_to_reg  out  2  0 = alu, 1 = mem, 2 = pc+4/pc-rel, 3 = imm
- jump, branch, inverse_branch, pc_offset  out  1 each
- reg_write, mem_rw  out  1 each
- rw_type  out  3  load/store size
- alu_control  out  4  alu_t
- md_op  out  3  = fun3 of the M instruction
- md_start  out  1  one-cycle start pulse to the mul/div unit
- md_done  out  1  result-valid pulse
- md_kill  out  1  abort pulse
- stall_out  out  1  stall request to IF/ID
- illegal  out  1  undecodable instruction

Behaviour:
- Decode is combinational, gated by valid_in. If !valid_in or illegal: reg_write=0, mem_rw=0, jump=0, branch=0, and every other output is 0. No x ever driven.
- Opcode decode:
  - R=01100: imm_sel=0, ALU result.
  - I=00100: alu_control={fun3==101 ? fun7[5] : 0, fun3}.
  - LOAD=00000: rw_type=fun3, mem_to_reg=1.
  - JALR=11001: jump=1, pc_offset=1, mem_to_reg=2.
  - S=01000: mem_rw=1.
  - SB=11000: branch=1, inverse_branch=fun3[0], alu_control EQ/NE/LT/GE/LTU/GEU.
  - JAL=11011: jump=1, mem_to_reg=2.
  - LUI=01101: mem_to_reg=3.
  - AUIPC=00101: mem_to_reg=2.
  - Any other opcode is illegal.
- R-type fun7 rules:
  - fun7=0000000: legal, alu_control={0, fun3}.
  - fun7=0100000: legal only for fun3 000 or 101, alu_control={1, fun3}.
  - fun7=0000001: M-op.
  - Any other fun7 value is illegal. Branch fun3 010/011 is illegal.
- M-op: reg_write=1, mem_to_reg=0, md_op=fun3. Latency LAT = DIV_LATENCY if fun3[2], else MUL_LATENCY.
- FSM states: IDLE, RUN, DONE. Reset forces IDLE, cnt=0, and all pulse outputs 0.
- IDLE:
  - Condition: valid_in & M-op & !flush & !stall_in.
  - Action: md_start=1, stall_out=1, cnt<=LAT-1, go to RUN.
  - If stall_in is high: no start, stay IDLE.
- RUN:
  - stall_out=1.
  - If flush: md_kill=1, go to IDLE.
  - Else if cnt==0: go to DONE.
  - Else cnt<=cnt-1.
- DONE:
  - md_done=1, stall_out=0 (M-op advances this cycle).
  - If stall_in: hold DONE, md_done stays high, no restart.
  - If flush: go to IDLE, no md_kill.
  - Else go to IDLE.
- Total stall_out high cycles per uninterrupted M-op = LAT+1. md_start is asserted exactly once per M-op.
- Back-to-back M-ops: the second starts in the IDLE cycle after DONE.
- stall_out also ORs stall_in only while in RUN; outside RUN the hazard unit owns stall.
- Reset mid-RUN: next cycle IDLE, no md_done, no md_kill.

Optional Feature:
- Macro: MD_SEQ_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles (32 bit).
  - Increments every cycle stall_out=1.
  - Saturates at 0xFFFF_FFFF.
  - Clears to 0 on rst.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- opcode=01100, fun7=0100000, fun3=000, valid_in=1 -> alu_control=4'b1000, reg_write=1, stall_out=0, illegal=0.
- opcode=01100, fun7=0000001, fun3=100 (DIV), DIV_LATENCY=33 -> md_start once, stall_out high 34 cycles, md_done in cycle 35, md_op=100.
- MUL (fun3=000), MUL_LATENCY=3, flush asserted in 2nd RUN cycle -> md_kill one cycle, next cycle IDLE, no md_done.
- DONE state with stall_in=1 for 2 cycles -> FSM holds DONE, md_done high 3 cycles, md_start not reasserted.
- opcode=11111, or opcode=11000 with fun3=010 -> illegal=1, reg_write=0, mem_rw=0, jump=0, branch=0.
- With MD_SEQ_STALL_CNT_EN: two MULs, MUL_LATENCY=3 -> stall_cycles=8; rst -> stall_cycles=0.

Source files
------------

// File: rtl/md_seq_controller_if.sv
// ID-stage decode bus between the ID stage (master) and md_seq_controller (slave).
// Carries the instruction fields in and the decoded controls / mul-div sequencing out.
interface md_seq_controller_if;
  logic       valid_in;
  logic [4:0] opcode;
  logic [2:0] fun3;
  logic [6:0] fun7;
  logic       stall_in;
  logic       flush;

  logic [2:0] imm_sel;
  logic       alu_src_b;
  logic [1:0] mem_to_reg;
  logic       jump;
  logic       branch;
  logic       inverse_branch;
  logic       pc_offset;
  logic       reg_write;
  logic       mem_rw;
  logic [2:0] rw_type;
  logic [3:0] alu_control;
  logic [2:0] md_op;
  logic       md_start;
  logic       md_done;
  logic       md_kill;
  logic       stall_out;
  logic       illegal;

  modport master (
    output valid_in, opcode, fun3, fun7, stall_in, flush,
    input  imm_sel, alu_src_b, mem_to_reg, jump, branch, inverse_branch, pc_offset,
    input  reg_write, mem_rw, rw_type, alu_control, md_op,
    input  md_start, md_done, md_kill, stall_out, illegal
  );

  modport slave (
    input  valid_in, opcode, fun3, fun7, stall_in, flush,
    output imm_sel, alu_src_b, mem_to_reg, jump, branch, inverse_branch, pc_offset,
    output reg_write, mem_rw, rw_type, alu_control, md_op,
    output md_start, md_done, md_kill, stall_out, illegal
  );
endinterface

// File: rtl/md_seq_controller.sv
// ID-stage RV32IM decoder plus mul/div sequencer. Latency: decode is combinational; an M-op holds
// IF/ID for LAT+1 cycles. Backpressure: stall_in blocks a start and holds DONE. Option: MD_SEQ_STALL_CNT_EN.
module md_seq_controller #(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 33,
  parameter int CNT_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MD_SEQ_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  md_seq_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } immgen_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_EQ   = 4'b1001,
    ALU_NE   = 4'b1010,
    ALU_LT   = 4'b1011,
    ALU_GE   = 4'b1100,
    ALU_SRA  = 4'b1101,
    ALU_LTU  = 4'b1110,
    ALU_GEU  = 4'b1111
  } alu_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] OPC_R     = 5'b01100;
  localparam logic [4:0] OPC_I     = 5'b00100;
  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_JALR  = 5'b11001;
  localparam logic [4:0] OPC_S     = 5'b01000;
  localparam logic [4:0] OPC_SB    = 5'b11000;
  localparam logic [4:0] OPC_JAL   = 5'b11011;
  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;

  // Counter preload is LAT-1: the IDLE start cycle plus LAT RUN cycles give LAT+1 stall cycles.
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY - 1);

  logic [2:0] imm_sel_d;
  logic       alu_src_b_d;
  logic [1:0] mem_to_reg_d;
  logic       jump_d;
  logic       branch_d;
  logic       inv_d;
  logic       pc_off_d;
  logic       reg_write_d;
  logic       mem_rw_d;
  logic [2:0] rw_type_d;
  logic [3:0] alu_d;
  logic [2:0] md_op_d;
  logic       m_op;
  logic       bad;

  always_comb begin
    imm_sel_d    = IMM_NONE;
    alu_src_b_d  = 1'b0;
    mem_to_reg_d = 2'd0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    inv_d        = 1'b0;
    pc_off_d     = 1'b0;
    reg_write_d  = 1'b0;
    mem_rw_d     = 1'b0;
    rw_type_d    = 3'd0;
    alu_d        = ALU_ADD;
    md_op_d      = 3'd0;
    m_op         = 1'b0;
    bad          = 1'b0;
    case (bus.opcode)
      OPC_R: begin
        reg_write_d = 1'b1;
        case (bus.fun7)
          7'b0000000: alu_d = {1'b0, bus.fun3};
          7'b0100000: begin
            alu_d = {1'b1, bus.fun3};
            bad   = !((bus.fun3 == 3'b000) || (bus.fun3 == 3'b101));
          end
          7'b0000001: begin
            m_op    = 1'b1;
            md_op_d = bus.fun3;
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_I: begin
        reg_write_d = 1'b1;
        alu_src_b_d = 1'b1;
        imm_sel_d   = IMM_I;
        alu_d       = {(bus.fun3 == 3'b101) ? bus.fun7[5] : 1'b0, bus.fun3};
      end
      OPC_LOAD: begin
        reg_write_d  = 1'b1;
        alu_src_b_d  = 1'b1;
        imm_sel_d    = IMM_I;
        rw_type_d    = bus.fun3;
        mem_to_reg_d = 2'd1;
      end
      OPC_JALR: begin
        reg_write_d  = 1'b1;
        alu_src_b_d  = 1'b1;
        imm_sel_d    = IMM_I;
        jump_d       = 1'b1;
        pc_off_d     = 1'b1;
        mem_to_reg_d = 2'd2;
      end
      OPC_S: begin
        alu_src_b_d = 1'b1;
        imm_sel_d   = IMM_S;
        mem_rw_d    = 1'b1;
        rw_type_d   = bus.fun3;
      end
      OPC_SB: begin
        imm_sel_d = IMM_B;
        branch_d  = 1'b1;
        inv_d     = bus.fun3[0];
        case (bus.fun3)
          3'b000:  alu_d = ALU_EQ;
          3'b001:  alu_d = ALU_NE;
          3'b100:  alu_d = ALU_LT;
          3'b101:  alu_d = ALU_GE;
          3'b110:  alu_d = ALU_LTU;
          3'b111:  alu_d = ALU_GEU;
          default: bad   = 1'b1;
        endcase
      end
      OPC_JAL: begin
        reg_write_d  = 1'b1;
        imm_sel_d    = IMM_J;
        jump_d       = 1'b1;
        mem_to_reg_d = 2'd2;
      end
      OPC_LUI: begin
        reg_write_d  = 1'b1;
        imm_sel_d    = IMM_U;
        alu_src_b_d  = 1'b1;
        mem_to_reg_d = 2'd3;
      end
      OPC_AUIPC: begin
        reg_write_d  = 1'b1;
        imm_sel_d    = IMM_U;
        alu_src_b_d  = 1'b1;
        mem_to_reg_d = 2'd2;
      end
      default: bad = 1'b1;
    endcase
  end

  // Anything not valid or not decodable drives all-zero controls.
  logic live;
  logic mop_live;
  assign live     = bus.valid_in & ~bad;
  assign mop_live = live & m_op;

  assign bus.illegal        = bus.valid_in & bad;
  assign bus.imm_sel        = live ? imm_sel_d    : 3'd0;
  assign bus.alu_src_b      = live & alu_src_b_d;
  assign bus.mem_to_reg     = live ? mem_to_reg_d : 2'd0;
  assign bus.jump           = live & jump_d;
  assign bus.branch         = live & branch_d;
  assign bus.inverse_branch = live & inv_d;
  assign bus.pc_offset      = live & pc_off_d;
  assign bus.reg_write      = live & reg_write_d;
  assign bus.mem_rw         = live & mem_rw_d;
  assign bus.rw_type        = live ? rw_type_d    : 3'd0;
  assign bus.alu_control    = live ? alu_d        : 4'd0;
  assign bus.md_op          = live ? md_op_d      : 3'd0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             start;

  assign start = ~rst & (state == S_IDLE) & mop_live & ~bus.flush & ~bus.stall_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            cnt   <= bus.fun3[2] ? DIV_CNT : MUL_CNT;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          // A stalled M-op keeps its result presented; flush or release both just retire to IDLE.
          if (!bus.stall_in) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.md_start  = start;
  assign bus.md_kill   = ~rst & (state == S_RUN) & bus.flush;
  assign bus.md_done   = ~rst & (state == S_DONE);
  assign bus.stall_out = start | (~rst & (state == S_RUN));

`ifdef MD_SEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (bus.stall_out && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_md_seq_controller.sv
// Directed bench for md_seq_controller: decode vectors and mul/div sequencing scenarios.
module tb_md_seq_controller;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  md_seq_controller_if bus();
`ifdef MD_SEQ_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  md_seq_controller #(
    .MUL_LATENCY(3),
    .DIV_LATENCY(33),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef MD_SEQ_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic v, input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7);
    @(posedge clk); #1;
    bus.valid_in = v;
    bus.opcode   = op;
    bus.fun3     = f3;
    bus.fun7     = f7;
    @(negedge clk);
  endtask

  task automatic run_seq(input logic [2:0] f3, input int ops, input int ncyc, input int flush_c,
                         input int stall_lo, input int stall_hi,
                         output int n_start, output int n_stall, output int n_done,
                         output int n_kill, output int first_done, output int first_kill,
                         output logic [2:0] done_op);
    int completed;
    completed = 0; n_start = 0; n_stall = 0; n_done = 0; n_kill = 0;
    first_done = 0; first_kill = 0; done_op = 3'd0;
    @(posedge clk); #1;
    bus.opcode = 5'b01100;
    bus.fun7   = 7'b0000001;
    bus.fun3   = f3;
    for (int c = 1; c <= ncyc; c++) begin
      bus.valid_in = (completed < ops);
      bus.flush    = (c == flush_c);
      bus.stall_in = (c >= stall_lo) && (c <= stall_hi);
      @(negedge clk);
      if (bus.md_start)  n_start++;
      if (bus.stall_out) n_stall++;
      if (bus.md_done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = c;
          done_op    = bus.md_op;
        end
        if (!bus.stall_in) completed++;
      end
      if (bus.md_kill) begin
        n_kill++;
        if (first_kill == 0) first_kill = c;
        completed++;
      end
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
    bus.flush    = 1'b0;
    bus.stall_in = 1'b0;
  endtask

  int ns, nst, nd, nk, fd, fk;
  logic [2:0] dop;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.valid_in = 1'b0; bus.opcode = 5'd0; bus.fun3 = 3'd0; bus.fun7 = 7'd0;
    bus.stall_in = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", bus.stall_out, 0);
    chk("rst_start", bus.md_start, 0);
    chk("rst_done",  bus.md_done, 0);
    chk("rst_kill",  bus.md_kill, 0);
    chk("rst_rw",    bus.reg_write, 0);
`ifdef MD_SEQ_STALL_CNT_EN
    chk("rst_scnt",  stall_cycles, 0);
`endif

    apply(1, 5'b01100, 3'b000, 7'b0100000);
    chk("sub_alu", bus.alu_control, 4'b1000);
    chk("sub_rw",  bus.reg_write, 1);
    chk("sub_stall", bus.stall_out, 0);
    chk("sub_ill", bus.illegal, 0);
    chk("sub_imm", bus.imm_sel, 0);
    chk("sub_m2r", bus.mem_to_reg, 0);

    apply(1, 5'b00100, 3'b101, 7'b0100000);
    chk("srai_alu", bus.alu_control, 4'b1101);
    chk("srai_srcb", bus.alu_src_b, 1);

    apply(1, 5'b00000, 3'b010, 7'b0000000);
    chk("lw_rwt", bus.rw_type, 3'b010);
    chk("lw_m2r", bus.mem_to_reg, 1);
    chk("lw_rw",  bus.reg_write, 1);

    apply(1, 5'b01000, 3'b010, 7'b0000000);
    chk("sw_mem", bus.mem_rw, 1);
    chk("sw_rw",  bus.reg_write, 0);

    apply(1, 5'b11000, 3'b001, 7'b0000000);
    chk("bne_br",  bus.branch, 1);
    chk("bne_inv", bus.inverse_branch, 1);
    chk("bne_rw",  bus.reg_write, 0);

    apply(1, 5'b11001, 3'b000, 7'b0000000);
    chk("jalr_j",   bus.jump, 1);
    chk("jalr_pco", bus.pc_offset, 1);
    chk("jalr_m2r", bus.mem_to_reg, 2);

    apply(1, 5'b01101, 3'b000, 7'b0000000);
    chk("lui_m2r", bus.mem_to_reg, 3);

    apply(1, 5'b11111, 3'b000, 7'b0000000);
    chk("ill_op",    bus.illegal, 1);
    chk("ill_op_rw", bus.reg_write, 0);
    chk("ill_op_mem", bus.mem_rw, 0);
    chk("ill_op_j",  bus.jump, 0);
    chk("ill_op_br", bus.branch, 0);

    apply(1, 5'b11000, 3'b010, 7'b0000000);
    chk("ill_br",    bus.illegal, 1);
    chk("ill_br_br", bus.branch, 0);
    chk("ill_br_alu", bus.alu_control, 0);

    apply(1, 5'b01100, 3'b001, 7'b0100000);
    chk("ill_f7",    bus.illegal, 1);
    chk("ill_f7_rw", bus.reg_write, 0);

    apply(0, 5'b01100, 3'b000, 7'b0000000);
    chk("nv_rw",  bus.reg_write, 0);
    chk("nv_ill", bus.illegal, 0);

    run_seq(3'b100, 1, 40, 0, 0, 0, ns, nst, nd, nk, fd, fk, dop);
    chk("div_start", ns, 1);
    chk("div_stall", nst, 34);
    chk("div_done_cyc", fd, 35);
    chk("div_ndone", nd, 1);
    chk("div_kill", nk, 0);
    chk("div_mdop", dop, 3'b100);

    run_seq(3'b000, 1, 8, 3, 0, 0, ns, nst, nd, nk, fd, fk, dop);
    chk("mflush_start", ns, 1);
    chk("mflush_kill", nk, 1);
    chk("mflush_kcyc", fk, 3);
    chk("mflush_done", nd, 0);
    chk("mflush_stall", nst, 3);

    run_seq(3'b000, 1, 10, 0, 5, 6, ns, nst, nd, nk, fd, fk, dop);
    chk("dstall_start", ns, 1);
    chk("dstall_done", nd, 3);
    chk("dstall_dcyc", fd, 5);
    chk("dstall_stall", nst, 4);
    chk("dstall_kill", nk, 0);

    run_seq(3'b000, 1, 8, 5, 0, 0, ns, nst, nd, nk, fd, fk, dop);
    chk("dflush_done", nd, 1);
    chk("dflush_kill", nk, 0);
    chk("dflush_start", ns, 1);

    run_seq(3'b011, 1, 10, 0, 1, 1, ns, nst, nd, nk, fd, fk, dop);
    chk("istall_start", ns, 1);
    chk("istall_dcyc", fd, 6);
    chk("istall_stall", nst, 4);
    chk("istall_mdop", dop, 3'b011);

    @(posedge clk); #1;
    bus.valid_in = 1'b1; bus.opcode = 5'b01100; bus.fun7 = 7'b0000001; bus.fun3 = 3'b100;
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_run_stall", bus.stall_out, 1);
    @(posedge clk); #1;
    rst = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    chk("mrst_kill", bus.md_kill, 0);
    chk("mrst_done", bus.md_done, 0);
    @(posedge clk); #1;
    rst = 1'b0; bus.flush = 1'b0; bus.valid_in = 1'b0;
    @(negedge clk);
    chk("mrst_idle_stall", bus.stall_out, 0);
    chk("mrst_idle_done", bus.md_done, 0);
    chk("mrst_idle_kill", bus.md_kill, 0);

    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_seq(3'b001, 2, 12, 0, 0, 0, ns, nst, nd, nk, fd, fk, dop);
    chk("b2b_start", ns, 2);
    chk("b2b_stall", nst, 8);
    chk("b2b_done", nd, 2);
    chk("b2b_dcyc", fd, 5);
`ifdef MD_SEQ_STALL_CNT_EN
    chk("scnt_b2b", stall_cycles, 8);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("scnt_rst", stall_cycles, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
